// File: rtl/sfifo_rd_arbiter.sv
// sfifo_rd_arbiter: round-robin sharing of one synchronous-FIFO read port among NumReq consumers.
// Optional macro SFIFO_ARB_BURST_EN lets one grant cover up to MaxBurst reads (default: one read per grant).

module sfifo_rd_arbiter #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned DataWidth = 8,
    parameter int unsigned MaxBurst  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NumReq-1:0]    ReqVec,
    input  logic                 FIFOEmpty,
    input  logic [DataWidth-1:0] FIFORdData,
    output logic                 FIFORdReq,
    output logic [NumReq-1:0]    GntVec,
    output logic [NumReq-1:0]    RdValid,
    output logic [DataWidth-1:0] RdData,
    output logic                 Busy
);

    localparam int unsigned     IdxW     = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam logic [IdxW-1:0] LastInit = IdxW'(NumReq - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    state_e            state_q;
    logic [NumReq-1:0] gnt_q;
    logic [NumReq-1:0] rd_valid_q;
    logic [IdxW-1:0]   gidx_q;
    logic [IdxW-1:0]   last_q;
    logic [IdxW-1:0]   rr_cand;
    logic [IdxW-1:0]   pick_idx;
    logic              start_grant;
    logic              gnt_req;
    logic              accept;
    logic              burst_done;
    logic              grant_end;

    if (NumReq < 2 || MaxBurst < 1) begin : g_param_check
        $error("sfifo_rd_arbiter: NumReq must be >= 2 and MaxBurst >= 1");
    end

    // Round-robin pick: scan offsets from the far end down so the nearest requester above last_q wins.
    always_comb begin
        pick_idx = '0;
        rr_cand  = '0;
        for (int unsigned k = NumReq; k > 0; k--) begin
            rr_cand = IdxW'((32'(last_q) + k) % NumReq);
            if (ReqVec[rr_cand]) begin
                pick_idx = rr_cand;
            end
        end
    end

    assign gnt_req     = |(gnt_q & ReqVec);
    assign accept      = gnt_req && !FIFOEmpty;
    assign start_grant = (state_q == ST_IDLE) && (|ReqVec) && !FIFOEmpty;
    assign grant_end   = !gnt_req || FIFOEmpty || (accept && burst_done);

`ifdef SFIFO_ARB_BURST_EN
    localparam int unsigned CntW = $clog2(MaxBurst) + 1;

    logic [CntW-1:0] cnt_q;

    // Reads accepted under the current grant; saturates at MaxBurst because the grant ends there.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (start_grant) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end

    assign burst_done = (cnt_q == CntW'(MaxBurst - 1));
`else
    assign burst_done = 1'b1;
`endif

    // Arbitration FSM with registered grant and read-valid outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            gidx_q     <= '0;
            last_q     <= LastInit;
            rd_valid_q <= '0;
        end else begin
            rd_valid_q <= accept ? gnt_q : '0;
            case (state_q)
                ST_IDLE: begin
                    if (start_grant) begin
                        state_q <= ST_GRANT;
                        gnt_q   <= NumReq'(1) << pick_idx;
                        gidx_q  <= pick_idx;
                    end
                end
                ST_GRANT: begin
                    if (grant_end) begin
                        state_q <= ST_IDLE;
                        gnt_q   <= '0;
                        last_q  <= gidx_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    gnt_q   <= '0;
                end
            endcase
        end
    end

    assign FIFORdReq = accept;
    assign GntVec    = gnt_q;
    assign RdValid   = rd_valid_q;
    assign RdData    = FIFORdData;
    assign Busy      = (state_q == ST_GRANT);

endmodule

// File: tb/tb_sfifo_rd_arbiter.sv
// Self-checking bench for sfifo_rd_arbiter: vector table, directed corner sequences and
// randomized traffic against a cycle-level reference model of the arbitration rules.

module tb_sfifo_rd_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;
`ifdef SFIFO_ARB_BURST_EN
    localparam int LIMIT = MB;
`else
    localparam int LIMIT = 1;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NR-1:0] ReqVec = '0;
    logic          FIFOEmpty = 1'b1;
    logic [DW-1:0] FIFORdData = '0;
    logic          FIFORdReq;
    logic [NR-1:0] GntVec;
    logic [NR-1:0] RdValid;
    logic [DW-1:0] RdData;
    logic          Busy;

    sfifo_rd_arbiter #(.NumReq(NR), .DataWidth(DW), .MaxBurst(MB)) dut (
        .clk        (clk),
        .reset      (reset),
        .ReqVec     (ReqVec),
        .FIFOEmpty  (FIFOEmpty),
        .FIFORdData (FIFORdData),
        .FIFORdReq  (FIFORdReq),
        .GntVec     (GntVec),
        .RdValid    (RdValid),
        .RdData     (RdData),
        .Busy       (Busy)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] fq[$];
    int            wctr = 0;

    // Reference model state
    bit            m_busy;
    int            m_owner;
    int            m_last;
    int            m_cnt;
    bit            m_rv;
    int            m_rvown;
    logic [DW-1:0] m_rvword;

    // Outputs sampled at the last negedge
    logic [NR-1:0] obs_gnt;
    logic [NR-1:0] obs_rv;
    logic          obs_rdreq;
    logic          obs_busy;
    logic [DW-1:0] obs_data;

    // Grant statistics from run_collect
    int g_own[$];
    int g_reads[$];
    int gaps[$];
    int rv_total;

    typedef struct {
        logic [NR-1:0] req;
        int            push;
        logic [NR-1:0] gnt;
        logic [NR-1:0] rv;
        logic          rdreq;
        logic          busy;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic int rr_pick(input int last, input logic [NR-1:0] req);
        for (int k = 1; k <= NR; k++) begin
            int i;
            i = (last + k) % NR;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    function automatic int oh2idx(input logic [NR-1:0] oh);
        for (int i = 0; i < NR; i++) begin
            if (oh[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy   = 1'b0;
        m_owner  = 0;
        m_last   = NR - 1;
        m_cnt    = 0;
        m_rv     = 1'b0;
        m_rvown  = 0;
        m_rvword = '0;
    endtask

    // One clock cycle: apply inputs at posedge+1, check at negedge, advance model/FIFO at posedge.
    task automatic cycle(input logic [NR-1:0] req, input int npush);
        logic [NR-1:0] e_gnt;
        logic [NR-1:0] e_rv;
        logic          e_rdreq;
        logic [DW-1:0] front;
        logic [DW-1:0] word;
        bit            empty;
        bit            popped;
        ReqVec = req;
        for (int i = 0; i < npush; i++) begin
            fq.push_back(DW'(wctr));
            wctr++;
        end
        empty     = (fq.size() == 0);
        FIFOEmpty = empty;
        front     = empty ? '0 : fq[0];
        e_gnt     = m_busy ? (NR'(1) << m_owner) : '0;
        e_rdreq   = m_busy && req[m_owner] && !empty;
        e_rv      = m_rv ? (NR'(1) << m_rvown) : '0;
        @(negedge clk);
        obs_gnt   = GntVec;
        obs_rv    = RdValid;
        obs_rdreq = FIFORdReq;
        obs_busy  = Busy;
        obs_data  = RdData;
        chk("gnt", 32'(obs_gnt), 32'(e_gnt));
        chk("rdvalid", 32'(obs_rv), 32'(e_rv));
        chk("rdreq", 32'(obs_rdreq), 32'(e_rdreq));
        chk("busy", 32'(obs_busy), 32'(m_busy));
        if (m_rv) chk("rddata", 32'(obs_data), 32'(m_rvword));
        @(posedge clk);
        if (!m_busy) begin
            m_rv = 1'b0;
            if (req != '0 && !empty) begin
                m_owner = rr_pick(m_last, req);
                m_busy  = 1'b1;
                m_cnt   = 0;
            end
        end else begin
            m_rv     = e_rdreq;
            m_rvown  = m_owner;
            m_rvword = front;
            if (e_rdreq) m_cnt++;
            if (!req[m_owner] || empty || (e_rdreq && m_cnt >= LIMIT)) begin
                m_busy = 1'b0;
                m_last = m_owner;
            end
        end
        popped = (obs_rdreq === 1'b1) && (fq.size() > 0);
        word   = popped ? fq.pop_front() : DW'($urandom);
        #1;
        FIFORdData = word;
    endtask

    // Asserted at posedge+1; outputs must clear without waiting for a clock edge.
    task automatic do_reset(input bit flush);
        reset = 1'b1;
        if (flush) fq.delete();
        FIFOEmpty = (fq.size() == 0);
        model_reset();
        #1;
        chk("rst_gnt", 32'(GntVec), 32'(0));
        chk("rst_rdvalid", 32'(RdValid), 32'(0));
        chk("rst_rdreq", 32'(FIFORdReq), 32'(0));
        chk("rst_busy", 32'(Busy), 32'(0));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_collect(input logic [NR-1:0] req, input int npush, input int ncyc);
        logic [NR-1:0] prev;
        int            idle;
        prev = '0;
        idle = 0;
        g_own.delete();
        g_reads.delete();
        gaps.delete();
        rv_total = 0;
        for (int c = 0; c < ncyc; c++) begin
            cycle(req, (c == 0) ? npush : 0);
            if (obs_gnt != '0 && prev == '0) begin
                if (g_own.size() > 0) gaps.push_back(idle);
                g_own.push_back(oh2idx(obs_gnt));
                g_reads.push_back(0);
            end
            if (obs_gnt == '0) idle++;
            else idle = 0;
            if (obs_gnt != '0 && obs_rdreq === 1'b1 && g_reads.size() > 0)
                g_reads[g_reads.size()-1]++;
            if (obs_rv != '0) rv_total++;
            prev = obs_gnt;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t          tbl[12];
        logic [NR-1:0] req;
        logic [DW-1:0] got[3];
        int            nrv;
        int            first;
        int            np;

        model_reset();
        @(posedge clk);
        #1;
        do_reset(1'b1);

        // FIFO empty for 10 cycles with two requesters, then one word arrives
        for (int i = 0; i < 10; i++) tbl[i] = '{req: 4'b0011, push: 0, gnt: 4'b0000, rv: 4'b0000, rdreq: 1'b0, busy: 1'b0};
        tbl[10] = '{req: 4'b0011, push: 1, gnt: 4'b0000, rv: 4'b0000, rdreq: 1'b0, busy: 1'b0};
        tbl[11] = '{req: 4'b0011, push: 0, gnt: 4'b0001, rv: 4'b0000, rdreq: 1'b1, busy: 1'b1};
        for (int i = 0; i < 12; i++) begin
            cycle(tbl[i].req, tbl[i].push);
            chk($sformatf("tbl%0d_gnt", i), 32'(obs_gnt), 32'(tbl[i].gnt));
            chk($sformatf("tbl%0d_rv", i), 32'(obs_rv), 32'(tbl[i].rv));
            chk($sformatf("tbl%0d_rdreq", i), 32'(obs_rdreq), 32'(tbl[i].rdreq));
            chk($sformatf("tbl%0d_busy", i), 32'(obs_busy), 32'(tbl[i].busy));
        end

        // Reset right after an accepted read: its RdValid is lost, arbitration restarts at 0
        do_reset(1'b1);
        cycle(4'b1111, 6);
        cycle(4'b1111, 0);
        chk("t6_pre_gnt", 32'(obs_gnt), 32'(4'b0001));
        chk("t6_pre_rdreq", 32'(obs_rdreq), 32'(1));
        do_reset(1'b0);
        cycle(4'b1111, 0);
        chk("t6_post_rv", 32'(obs_rv), 32'(0));
        chk("t6_post_gnt", 32'(obs_gnt), 32'(0));
        cycle(4'b1111, 0);
        chk("t6_restart_gnt", 32'(obs_gnt), 32'(4'b0001));

`ifdef SFIFO_ARB_BURST_EN
        // Single requester drains A,B,C in one burst
        do_reset(1'b1);
        fq.push_back(8'hA0);
        fq.push_back(8'hB1);
        fq.push_back(8'hC2);
        nrv   = 0;
        first = -1;
        for (int c = 0; c < 8; c++) begin
            cycle(4'b0001, 0);
            if (c == 1) chk("t1_gnt", 32'(obs_gnt), 32'(4'b0001));
            if (obs_rv == 4'b0001) begin
                if (nrv == 0) first = c;
                if (nrv < 3) got[nrv] = obs_data;
                nrv++;
            end
        end
        chk("t1_nrv", 32'(nrv), 32'(3));
        chk("t1_first", 32'(first), 32'(2));
        chk("t1_d0", 32'(got[0]), 32'(8'hA0));
        chk("t1_d1", 32'(got[1]), 32'(8'hB1));
        chk("t1_d2", 32'(got[2]), 32'(8'hC2));
        chk("t1_busy", 32'(obs_busy), 32'(0));

        // Two requesters, 10 words: bursts of 4, 4, 2
        do_reset(1'b1);
        run_collect(4'b0101, 10, 40);
        chk("t3_ngrants", 32'(g_own.size()), 32'(3));
        if (g_own.size() >= 3) begin
            chk("t3_own0", 32'(g_own[0]), 32'(0));
            chk("t3_own1", 32'(g_own[1]), 32'(2));
            chk("t3_own2", 32'(g_own[2]), 32'(0));
            chk("t3_rd0", 32'(g_reads[0]), 32'(4));
            chk("t3_rd1", 32'(g_reads[1]), 32'(4));
            chk("t3_rd2", 32'(g_reads[2]), 32'(2));
        end
        chk("t3_rvtotal", 32'(rv_total), 32'(10));
        chk("t3_busy", 32'(obs_busy), 32'(0));

        // Consumer 1 withdraws after two reads; next grant goes to consumer 3
        do_reset(1'b1);
        cycle(4'b0010, 8);
        cycle(4'b0010, 0);
        chk("t4_gnt", 32'(obs_gnt), 32'(4'b0010));
        cycle(4'b0010, 0);
        chk("t4_rdreq2", 32'(obs_rdreq), 32'(1));
        cycle(4'b1001, 0);
        chk("t4_drop_rdreq", 32'(obs_rdreq), 32'(0));
        cycle(4'b1001, 0);
        chk("t4_idle_gnt", 32'(obs_gnt), 32'(0));
        cycle(4'b1001, 0);
        chk("t4_next_gnt", 32'(obs_gnt), 32'(4'b1000));
        for (int c = 0; c < 4; c++) cycle(4'b0000, 0);
`else
        // All four requesting, 8 words: strict word-level rotation with one idle cycle between grants
        do_reset(1'b1);
        run_collect(4'b1111, 8, 30);
        chk("t2_ngrants", 32'(g_own.size()), 32'(8));
        for (int i = 0; i < g_own.size() && i < 8; i++) begin
            chk($sformatf("t2_own%0d", i), 32'(g_own[i]), 32'(i % NR));
            chk($sformatf("t2_rd%0d", i), 32'(g_reads[i]), 32'(1));
        end
        for (int i = 0; i < gaps.size(); i++) chk($sformatf("t2_gap%0d", i), 32'(gaps[i]), 32'(1));
        chk("t2_rvtotal", 32'(rv_total), 32'(8));
`endif

        // Randomized traffic against the model
        do_reset(1'b1);
        req = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < NR; b++) begin
                if ($urandom_range(0, 7) == 0) req[b] = ~req[b];
            end
            np = (fq.size() < 12 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0;
            cycle(req, np);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
